ex_flag_stage: RTL and testbench
================================

EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1: the execute-stage result on the inputs is a real instruction.
REQ-004 SHALL have port alu_out, input, 16: final ALU result, already saturated where applicable.
REQ-005 SHALL have port alu_err, input, 1: ALU overflow indication.
REQ-006 SHALL have port opcode, input, 4: instruction opcode.
REQ-007 SHALL have port dst_reg, input, 4: destination register index.
REQ-008 SHALL have port wr_en, input, 1: instruction writes the register file.
REQ-009 SHALL have port stall, input, 1: hold the stage.
REQ-010 SHALL have port flush, input, 1: kill the incoming instruction.
REQ-011 SHALL have port cond, input, 3: branch condition code.
REQ-012 SHALL have port out_valid, output, 1: registered valid.
REQ-013 SHALL have port out_data, output, 16: registered result.
REQ-014 SHALL have port out_dst, output, 4: registered destination.
REQ-015 SHALL have port out_wr_en, output, 1: registered write enable.
REQ-016 SHALL have port flag_z, flag_v, flag_n, output, 1 each: registered flags.
REQ-017 SHALL have port cond_true, output, 1: branch-taken decision.
REQ-018 SHALL have port ovfl_count, output, 8: saturating overflow event counter.

Function
REQ-019 SHALL define "accept" as in_valid & ~stall & ~flush at a rising clk edge.
REQ-020 On accept, out_valid<=1, out_data<=alu_out, out_dst<=dst_reg, out_wr_en<=wr_en; latency exactly 1 cycle.
REQ-021 When stall=1 and flush=0, all registers (pipe, flags, counter) SHALL hold their values.
REQ-022 When flush=1 (priority over stall), out_valid, out_wr_en, out_data and out_dst SHALL go to 0; flags and counter hold.
REQ-023 When in_valid=0, stall=0 and flush=0, out_valid<=0 and out_wr_en<=0; out_data and out_dst hold.
REQ-024 Flag updates SHALL happen only on accept:
  - ADD 0000, SUB 0001: Z<=(alu_out==0), N<=alu_out[15], V<=alu_err.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: Z only.
  - All other opcodes, including RED 0011 and PADDSB 0111: no flag change.
REQ-025 Z SHALL be computed on the saturated alu_out value, so a saturated 0x7FFF gives Z=0.
REQ-026 cond_true SHALL be combinational from the registered flags and cond:
  - 000: ~Z
  - 001: Z
  - 010: ~Z&~N
  - 011: N
  - 100: Z|(~Z&~N)
  - 101: N|Z
  - 110: V
  - 111: 1
REQ-027 cond_true SHALL NOT see the flags of the instruction being accepted in the same cycle; it sees them the next cycle.
REQ-028 ovfl_count SHALL increment by 1 on accept of ADD, SUB or PADDSB with alu_err=1.
REQ-029 ovfl_count SHALL saturate at 0xFF and never wrap.
REQ-030 Opcodes not listed SHALL pass through the pipe normally, with no flag or counter effect.

Reset
REQ-031 While rst_n=0, independent of clk, the outputs SHALL be:
  - out_valid=0, out_wr_en=0;
  - out_data=0x0000, out_dst=0;
  - flag_z=flag_v=flag_n=0;
  - ovfl_count=0x00.
REQ-032 Reset asserted mid-stall or mid-flush SHALL override both.
REQ-033 The first accept after rst_n rises SHALL behave as REQ-020.

Verification
REQ-034 Accept ADD, alu_out=0x0000, alu_err=0 -> next cycle out_valid=1, out_data=0, Z=1, N=0, V=0, cond 001 gives cond_true=1.
REQ-035 Accept SUB, alu_out=0x8000, alu_err=1, then accept XOR, alu_out=0x0005:
  - after SUB: N=1, V=1, Z=0, ovfl_count=1;
  - after XOR: Z=0, N=1 and V=1 retained, cond 110 gives cond_true=1.
REQ-036 stall=1 for 3 cycles with new ADD inputs -> outputs, flags and counter frozen; stall and flush together -> out_valid=0, flags unchanged.
REQ-037 Accept 300 PADDSB with alu_err=1 -> ovfl_count=0xFF and flags unchanged; one more ADD with alu_err=1 -> ovfl_count stays 0xFF.
REQ-038 Assert rst_n=0 between clock edges after REQ-035 -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ex_flag_stage.sv
// Execute-to-writeback pipeline register with condition flags, a branch
// condition evaluator and a saturating overflow event counter.
//
// Pipe control priority: reset > flush > stall > accept/idle.
// "accept" means in_valid is high while stall and flush are both low.
module ex_flag_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] alu_out,
  input  logic        alu_err,
  input  logic [3:0]  opcode,
  input  logic [3:0]  dst_reg,
  input  logic        wr_en,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  cond,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [3:0]  out_dst,
  output logic        out_wr_en,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic        cond_true,
  output logic [7:0]  ovfl_count
);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  logic accept;
  logic upd_znv;
  logic upd_z;
  logic cnt_evt;

  // Decode which state an accepted instruction is allowed to touch
  always_comb begin
    accept  = in_valid & ~stall & ~flush;
    upd_znv = accept & ((opcode == OP_ADD) | (opcode == OP_SUB));
    upd_z   = accept & ((opcode == OP_XOR) | (opcode == OP_SLL) |
                        (opcode == OP_SRA) | (opcode == OP_ROR));
    cnt_evt = accept & alu_err &
              ((opcode == OP_ADD) | (opcode == OP_SUB) | (opcode == OP_PADDSB));
  end

  // Pipe register: flush clears everything, stall holds, idle drops valid only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_wr_en <= 1'b0;
      out_data  <= 16'h0000;
      out_dst   <= 4'h0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_wr_en <= 1'b0;
      out_data  <= 16'h0000;
      out_dst   <= 4'h0;
    end else if (!stall) begin
      if (in_valid) begin
        out_valid <= 1'b1;
        out_wr_en <= wr_en;
        out_data  <= alu_out;
        out_dst   <= dst_reg;
      end else begin
        out_valid <= 1'b0;
        out_wr_en <= 1'b0;
      end
    end
  end

  // Flags: Z is taken from the already-saturated result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else if (upd_znv) begin
      flag_z <= (alu_out == 16'h0000);
      flag_n <= alu_out[15];
      flag_v <= alu_err;
    end else if (upd_z) begin
      flag_z <= (alu_out == 16'h0000);
    end
  end

  // Overflow event counter, sticks at its maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl_count <= 8'h00;
    end else if (cnt_evt && (ovfl_count != 8'hFF)) begin
      ovfl_count <= ovfl_count + 8'h01;
    end
  end

  // Branch decision from registered flags only, so it lags accept by a cycle
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = ~flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = ~flag_z & ~flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
      3'b101:  cond_true = flag_n | flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ex_flag_stage.sv
// Bench for ex_flag_stage: a table of hand-computed vectors, a PADDSB burst
// for counter saturation, and an asynchronous reset sequence.
module tb_ex_flag_stage;

  localparam int W = 34;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] alu_out;
  logic        alu_err;
  logic [3:0]  opcode;
  logic [3:0]  dst_reg;
  logic        wr_en;
  logic        stall;
  logic        flush;
  logic [2:0]  cond;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_dst;
  logic        out_wr_en;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        cond_true;
  logic [7:0]  ovfl_count;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        iv;
    logic [3:0]  op;
    logic [15:0] alu;
    logic        err;
    logic [3:0]  dst;
    logic        wr;
    logic        st;
    logic        fl;
    logic [2:0]  cc;
    logic        e_valid;
    logic [15:0] e_data;
    logic [3:0]  e_dst;
    logic        e_wr;
    logic        e_z;
    logic        e_v;
    logic        e_n;
    logic [7:0]  e_cnt;
    logic        e_ct;
  } vec_t;

  vec_t vecs[17];

  ex_flag_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .alu_out    (alu_out),
    .alu_err    (alu_err),
    .opcode     (opcode),
    .dst_reg    (dst_reg),
    .wr_en      (wr_en),
    .stall      (stall),
    .flush      (flush),
    .cond       (cond),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_dst    (out_dst),
    .out_wr_en  (out_wr_en),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .cond_true  (cond_true),
    .ovfl_count (ovfl_count)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic iv, logic [3:0] op, logic [15:0] alu, logic err,
                              logic [3:0] dst, logic wr, logic st, logic fl, logic [2:0] cc,
                              logic ev, logic [15:0] ed, logic [3:0] edst, logic ew,
                              logic ez, logic evf, logic en, logic [7:0] ecnt, logic ect);
    vec_t v;
    v.iv = iv; v.op = op; v.alu = alu; v.err = err; v.dst = dst; v.wr = wr;
    v.st = st; v.fl = fl; v.cc = cc;
    v.e_valid = ev; v.e_data = ed; v.e_dst = edst; v.e_wr = ew;
    v.e_z = ez; v.e_v = evf; v.e_n = en; v.e_cnt = ecnt; v.e_ct = ect;
    return v;
  endfunction

  function automatic logic [W-1:0] pack_exp(vec_t v);
    return {v.e_valid, v.e_data, v.e_dst, v.e_wr, v.e_z, v.e_v, v.e_n, v.e_cnt, v.e_ct};
  endfunction

  function automatic logic [W-1:0] pack_act();
    return {out_valid, out_data, out_dst, out_wr_en, flag_z, flag_v, flag_n, ovfl_count, cond_true};
  endfunction

  task automatic check_now(string name, logic [W-1:0] req);
    logic [W-1:0] act;
    act = pack_act();
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got valid=%0b data=%h dst=%h wr=%0b z=%0b v=%0b n=%0b cnt=%h ct=%0b, need valid=%0b data=%h dst=%h wr=%0b z=%0b v=%0b n=%0b cnt=%h ct=%0b",
               name, act[33], act[32:17], act[16:13], act[12], act[11], act[10], act[9], act[8:1], act[0],
               req[33], req[32:17], req[16:13], req[12], req[11], req[10], req[9], req[8:1], req[0]);
    end
  endtask

  // Driver: set inputs on the falling edge and record what the next edge must produce
  task automatic drive(vec_t v);
    @(negedge clk);
    in_valid = v.iv; opcode = v.op; alu_out = v.alu; alu_err = v.err;
    dst_reg = v.dst; wr_en = v.wr; stall = v.st; flush = v.fl; cond = v.cc;
    exp_q.push_back(pack_exp(v));
  endtask

  // Scoreboard: sample just after the rising edge and compare against the queue head
  task automatic sample(string name);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got 0 entries need 1", name);
    end else begin
      check_now(name, exp_q.pop_front());
    end
  endtask

  task automatic apply(vec_t v, string name);
    drive(v);
    sample(name);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b1;
    in_valid = 0; alu_out = 0; alu_err = 0; opcode = 0; dst_reg = 0;
    wr_en = 0; stall = 0; flush = 0; cond = 3'b000;

    //          iv op      alu      err dst  wr st fl cc      valid data     dst  wr z  v  n  cnt    ct
    vecs[0]  = mk(1, 4'h0, 16'h0000, 0, 4'h3, 1, 0, 0, 3'b001, 1, 16'h0000, 4'h3, 1, 1, 0, 0, 8'h00, 1);
    vecs[1]  = mk(1, 4'h1, 16'h8000, 1, 4'h5, 1, 0, 0, 3'b110, 1, 16'h8000, 4'h5, 1, 0, 1, 1, 8'h01, 1);
    vecs[2]  = mk(1, 4'h2, 16'h0005, 0, 4'h6, 1, 0, 0, 3'b110, 1, 16'h0005, 4'h6, 1, 0, 1, 1, 8'h01, 1);
    vecs[3]  = mk(1, 4'h0, 16'h0000, 1, 4'h9, 0, 1, 0, 3'b001, 1, 16'h0005, 4'h6, 1, 0, 1, 1, 8'h01, 0);
    vecs[4]  = mk(1, 4'h0, 16'h0000, 1, 4'h9, 0, 1, 0, 3'b011, 1, 16'h0005, 4'h6, 1, 0, 1, 1, 8'h01, 1);
    vecs[5]  = mk(1, 4'h0, 16'h0000, 1, 4'h9, 0, 1, 0, 3'b000, 1, 16'h0005, 4'h6, 1, 0, 1, 1, 8'h01, 1);
    vecs[6]  = mk(1, 4'h0, 16'h0000, 1, 4'h9, 1, 1, 1, 3'b010, 0, 16'h0000, 4'h0, 0, 0, 1, 1, 8'h01, 0);
    vecs[7]  = mk(1, 4'h8, 16'h0000, 1, 4'h2, 1, 0, 0, 3'b001, 1, 16'h0000, 4'h2, 1, 0, 1, 1, 8'h01, 0);
    vecs[8]  = mk(0, 4'h0, 16'hFFFF, 1, 4'hF, 1, 0, 0, 3'b101, 0, 16'h0000, 4'h2, 0, 0, 1, 1, 8'h01, 1);
    vecs[9]  = mk(1, 4'h0, 16'h7FFF, 1, 4'h4, 1, 0, 0, 3'b100, 1, 16'h7FFF, 4'h4, 1, 0, 1, 0, 8'h02, 1);
    vecs[10] = mk(1, 4'h4, 16'h0000, 1, 4'h1, 0, 0, 0, 3'b001, 1, 16'h0000, 4'h1, 0, 1, 1, 0, 8'h02, 1);
    vecs[11] = mk(1, 4'h3, 16'h1234, 1, 4'h8, 1, 0, 0, 3'b000, 1, 16'h1234, 4'h8, 1, 1, 1, 0, 8'h02, 0);
    vecs[12] = mk(1, 4'h7, 16'h8000, 1, 4'hA, 1, 0, 0, 3'b011, 1, 16'h8000, 4'hA, 1, 1, 1, 0, 8'h03, 0);
    vecs[13] = mk(1, 4'h5, 16'h0001, 0, 4'hB, 1, 0, 0, 3'b111, 1, 16'h0001, 4'hB, 1, 0, 1, 0, 8'h03, 1);
    vecs[14] = mk(1, 4'h6, 16'h0000, 0, 4'hC, 1, 0, 0, 3'b001, 1, 16'h0000, 4'hC, 1, 1, 1, 0, 8'h03, 1);
    vecs[15] = mk(1, 4'h0, 16'h5555, 1, 4'hD, 1, 0, 1, 3'b110, 0, 16'h0000, 4'h0, 0, 1, 1, 0, 8'h03, 1);
    vecs[16] = mk(1, 4'h1, 16'hFFFF, 0, 4'hE, 0, 0, 0, 3'b110, 1, 16'hFFFF, 4'hE, 0, 0, 0, 1, 8'h03, 0);

    // Reset state, held across clock edges with busy inputs
    #1 rst_n = 1'b0;
    in_valid = 1; opcode = 4'h0; alu_out = 16'h1111; alu_err = 1; wr_en = 1; cond = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", {1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
    @(negedge clk);
    in_valid = 0; alu_err = 0; wr_en = 0;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Saturating counter burst: flags z=0 v=0 n=1 from vec16 must not move
    for (int i = 0; i < 300; i++) begin
      int c;
      c = 3 + i + 1;
      if (c > 255) c = 255;
      v = mk(1, 4'h7, 16'h7FFF, 1, 4'h2, 1, 0, 0, 3'b011,
             1, 16'h7FFF, 4'h2, 1, 0, 0, 1, c[7:0], 1);
      apply(v, $sformatf("paddsb%0d", i));
    end
    v = mk(1, 4'h0, 16'h0001, 1, 4'h3, 1, 0, 0, 3'b110, 1, 16'h0001, 4'h3, 1, 0, 1, 0, 8'hFF, 1);
    apply(v, "add_at_sat");

    // Asynchronous reset between edges while stalled and flushed
    @(negedge clk);
    stall = 1; flush = 1; in_valid = 1; cond = 3'b110;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_now("async_reset", {1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // First accept after reset
    v = mk(1, 4'h0, 16'h0042, 0, 4'h1, 1, 0, 0, 3'b000, 1, 16'h0042, 4'h1, 1, 0, 0, 0, 8'h00, 1);
    apply(v, "first_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
